epcq_flash_sequencer: RTL and testbench
=======================================

# epcq_flash_sequencer

Command sequencer that drives the EPCQ parallel-flash IP (ALTASMI-style port set: read/rden/write/shift_bytes/wren/sector_erase/addr/datain, returning dataout/busy/data_valid/illegal_*). It is the initiator side of that interface. It turns single host commands (page program, sector erase, burst read) into correctly ordered IP handshakes. It sits between the register/readout bus used for remote firmware update and the flash IP block, and owns a 256-byte page buffer.

## Interface
Parameters:
- `BUSY_TIMEOUT`, default 2^26: max cycles to wait for a `busy` rise or fall; exceeding it aborts the command.

Ports:
- `clkin`  in  1  single clock, shared with the flash IP
- `reset`  in  1  synchronous, active-high
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  command handshake; accepted on the cycle both are high
- `cmd_op`  in  2  00 read, 01 page program, 10 sector erase, 11 reserved
- `cmd_addr`  in  32  flash byte address
- `cmd_len`  in  8  byte count minus 1 (1..256 bytes)
- `buf_we`, `buf_waddr`, `buf_wdata`  in  1, 8, 8  page-buffer write port
- `rd_valid`, `rd_data`  out  1, 8  read-data stream, one byte per pulse
- `done`, `err`  out  1, 2  end-of-command pulse; err 00 ok, 01 illegal (write or erase), 10 timeout, 11 bad argument
- `asmi_read`, `asmi_rden`, `asmi_write`, `asmi_wren`, `asmi_shift_bytes`, `asmi_sector_erase`  out  1 each  IP controls
- `asmi_bulk_erase`  out  1  tied 0
- `asmi_addr`  out  32  IP address
- `asmi_datain`  out  8  IP write data
- `asmi_en4b_addr`  out  1  constant 1 (4-byte addressing)
- `asmi_dataout`, `asmi_busy`, `asmi_data_valid`, `asmi_illegal_write`, `asmi_illegal_erase`  in  8, 1, 1, 1, 1  IP responses

## Operation
- States: IDLE, CHECK, SHIFT, PROG_REQ, ER_REQ, RD_REQ, WAIT_HI, WAIT_LO, RD_NEXT, DONE.
- IDLE:
  - `cmd_ready` = 1.
  - `buf_we` is honoured only in IDLE and ignored elsewhere.
  - Accepting a command latches op, addr, len.
  - Next state is CHECK.
- CHECK:
  - op 11 -> DONE, err 11.
  - Program with `addr[7:0] + len > 255` (page crossing) -> DONE, err 11. No IP activity in either case.
  - Otherwise go to SHIFT, ER_REQ or RD_REQ according to op.
- SHIFT (program only):
  - One byte per cycle: `asmi_shift_bytes` = 1, `asmi_datain` = buffer[i], for i = 0..len.
  - The buffer read is registered, so the first byte's fetch is issued one cycle before SHIFT.
  - Stalls (shift_bytes low, i held) while `asmi_busy` = 1.
- PROG_REQ:
  - One cycle: `asmi_write` = `asmi_wren` = 1, `asmi_addr` = latched addr.
  - Next state WAIT_HI.
- ER_REQ:
  - One cycle: `asmi_sector_erase` = `asmi_wren` = 1, `asmi_addr` = addr.
  - Next state WAIT_HI.
- RD_REQ:
  - One cycle `asmi_read` = 1.
  - `asmi_rden` = 1 is held from RD_REQ until `asmi_data_valid` is seen.
  - `asmi_addr` = addr + i.
  - Next state WAIT_HI.
- WAIT_HI:
  - Wait for `asmi_busy` = 1, then go to WAIT_LO.
  - For reads, a `data_valid` arriving before busy is also captured.
- WAIT_LO: wait for `asmi_busy` = 0.
  - Program/erase: sample `asmi_illegal_write` / `asmi_illegal_erase` on the falling-edge cycle -> err 01 or 00 -> DONE.
  - Read: the byte must have been captured, else err 10. Go to RD_NEXT.
- RD_NEXT:
  - If i == len -> DONE.
  - Otherwise i++, addr increments modulo 2^32 (0xFFFFFFFF wraps to 0), -> RD_REQ.
- DONE: one-cycle `done` with `err` valid, then IDLE.
- Timeout:
  - A counter clears on entering WAIT_HI and again on entering WAIT_LO.
  - Reaching `BUSY_TIMEOUT` -> DONE, err 10. All asmi controls are deasserted.

## Timing
- Reset values:
  - `cmd_ready` = 0 during reset, 1 the cycle after reset releases.
  - All `asmi_*` controls 0, `asmi_addr`/`asmi_datain` 0, `asmi_en4b_addr` 1.
  - `rd_valid`, `done` 0; `err` 00.
  - Page-buffer contents are not reset.
- Reset mid-command: returns to IDLE the next cycle. Outputs drop immediately and no `done` is produced.
- All outputs are registered.
- `rd_data` = `asmi_dataout` and `rd_valid` pulse occur one cycle after `asmi_data_valid`.
- `done` asserts 1 cycle after the terminating condition. For argument errors, `done` asserts 2 cycles after acceptance.
- Program with n bytes and busy idle:
  - SHIFT occupies exactly n cycles.
  - `asmi_write` is high on cycle 1 + n + 1 after acceptance.
- A new command can be accepted on the cycle after `done`.

## Structure
- Shared package `epcq_pkg`:
  - opcode constants (OP_READ, OP_PROG, OP_ERASE)
  - error codes (ERR_OK, ERR_ILLEGAL, ERR_TIMEOUT, ERR_ARG)
  - state enum
  - PAGE_BYTES = 256
- One sub-module, `epcq_page_buffer`: 256x8 simple dual-port RAM with a registered read port, inferable as M9K/M10K.
- FSM, counters and timeout live in the top module.

## Test plan
- Erase at 0x0001_0000 with a busy model high for 50 cycles:
  - one-cycle `asmi_sector_erase` + `asmi_wren` with `asmi_addr` = 0x0001_0000
  - then `done` with err 00.
- Program 4 bytes A1 B2 C3 D4 at 0x0000_0100:
  - `asmi_shift_bytes` for exactly 4 cycles carrying A1..D4 in order
  - then one `asmi_write` cycle at 0x100, then `done` with err 00.
- Program with addr 0x0000_01F0 and len 0x1F: `done` with err 11, with no asmi strobe ever asserted.
- Read 3 bytes at 0xFFFF_FFFF:
  - `asmi_addr` sequence FFFF_FFFF, 0000_0000, 0000_0001
  - three `rd_valid` pulses carrying the model data, then err 00.
- Erase with `asmi_illegal_erase` = 1 at busy fall gives err 01. A busy model stuck high, with `BUSY_TIMEOUT` = 100, gives err 10 at cycle 100 of WAIT_LO.
- Assert `reset` during SHIFT of a 256-byte program:
  - next cycle all asmi controls 0, and no `done`
  - then `cmd_ready` = 1 one cycle after reset releases.

Source files
------------

// File: rtl/epcq_pkg.sv
// Shared definitions for the EPCQ flash command sequencer.
// Contents: opcode and error encodings, sequencer state enum, page size,
// and the page-crossing check used to validate program commands.
package epcq_pkg;

    localparam int PAGE_BYTES = 256;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ARG     = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_PROG_REQ,
        ST_ER_REQ,
        ST_RD_REQ,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RD_NEXT,
        ST_DONE
    } state_e;

    // True when a program of (len+1) bytes starting at page offset 'ofs'
    // would run past the end of the 256-byte page.
    function automatic logic page_cross(input logic [7:0] ofs, input logic [7:0] len);
        logic [8:0] last;
        last = {1'b0, ofs} + {1'b0, len};
        return last > 9'd255;
    endfunction

endpackage

// File: rtl/epcq_page_buffer.sv
// 256x8 simple dual-port page buffer, one write port and one registered read port.
// Ports: clk_i; we_i/waddr_i/wdata_i write side; raddr_i in, rdata_o out one cycle later.
// Contents are never reset so the array maps onto a block RAM.
module epcq_page_buffer
    import epcq_pkg::*;
(
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [0:PAGE_BYTES-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/epcq_flash_sequencer.sv
// Initiator for the EPCQ flash IP: turns one host command (read/program/erase)
// into the ordered IP handshake; owns the 256-byte page buffer.
// Ports: cmd_* handshake, buf_* buffer fill, rd_* read stream, done/err status, asmi_* IP side.
module epcq_flash_sequencer
    import epcq_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 1 << 26
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        buf_we,
    input  logic [7:0]  buf_waddr,
    input  logic [7:0]  buf_wdata,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic [1:0]  err,
    output logic        asmi_read,
    output logic        asmi_rden,
    output logic        asmi_write,
    output logic        asmi_wren,
    output logic        asmi_shift_bytes,
    output logic        asmi_sector_erase,
    output logic        asmi_bulk_erase,
    output logic [31:0] asmi_addr,
    output logic [7:0]  asmi_datain,
    output logic        asmi_en4b_addr,
    input  logic [7:0]  asmi_dataout,
    input  logic        asmi_busy,
    input  logic        asmi_data_valid,
    input  logic        asmi_illegal_write,
    input  logic        asmi_illegal_erase
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        got_q, got_d;
    logic [1:0]  err_d;
    logic        cap;
    logic        tmo_hit;
    logic [7:0]  buf_raddr;
    logic [7:0]  buf_rdata;

    logic        cmd_ready_q, done_q, rd_valid_q;
    logic [1:0]  err_q;
    logic [7:0]  rd_data_q;
    logic        read_q, rden_q, write_q, wren_q, shift_q, erase_q;
    logic [31:0] aaddr_q;

    // Buffer is host-writable only while no command is in flight.
    epcq_page_buffer u_buf (
        .clk_i   (clkin),
        .we_i    (buf_we && (state_q == ST_IDLE)),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    assign tmo_hit = (tmo_q == TW'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        got_d     = got_q;
        tmo_d     = tmo_q + TW'(1);
        err_d     = ERR_OK;
        cap       = 1'b0;
        buf_raddr = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    idx_d   = 8'd0;
                    got_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // buf_raddr = idx_q = 0 here pre-fetches byte 0 for the first SHIFT cycle.
                if (op_q == OP_RSVD || (op_q == OP_PROG && page_cross(addr_q[7:0], len_q))) begin
                    state_d = ST_DONE;
                    err_d   = ERR_ARG;
                end else if (op_q == OP_PROG) begin
                    state_d = ST_SHIFT;
                end else if (op_q == OP_ERASE) begin
                    state_d = ST_ER_REQ;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_SHIFT: begin
                // A byte is consumed only on cycles where shift_bytes is actually presented.
                if (shift_q) begin
                    if (idx_q == len_q) begin
                        state_d = ST_PROG_REQ;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        buf_raddr = idx_d;
                    end
                end
            end
            ST_PROG_REQ, ST_ER_REQ: state_d = ST_WAIT_HI;
            ST_RD_REQ: begin
                cap     = asmi_data_valid;
                got_d   = asmi_data_valid;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (op_q == OP_READ) begin
                    cap   = asmi_data_valid && !got_q;
                    got_d = got_q || asmi_data_valid;
                end
                if (asmi_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_WAIT_LO: begin
                if (op_q == OP_READ) begin
                    cap   = asmi_data_valid && !got_q;
                    got_d = got_q || asmi_data_valid;
                end
                if (!asmi_busy) begin
                    if (op_q == OP_READ) begin
                        if (got_q || asmi_data_valid) begin
                            state_d = ST_RD_NEXT;
                        end else begin
                            state_d = ST_DONE;
                            err_d   = ERR_TIMEOUT;
                        end
                    end else begin
                        state_d = ST_DONE;
                        if ((op_q == OP_PROG) ? asmi_illegal_write : asmi_illegal_erase) begin
                            err_d = ERR_ILLEGAL;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_RD_NEXT: begin
                if (idx_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + 32'd1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q && (state_d == ST_WAIT_HI || state_d == ST_WAIT_LO)) begin
            tmo_d = '0;
        end
    end

    // Outputs are registered from next-state so they line up with the state register.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            got_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            read_q      <= 1'b0;
            rden_q      <= 1'b0;
            write_q     <= 1'b0;
            wren_q      <= 1'b0;
            shift_q     <= 1'b0;
            erase_q     <= 1'b0;
            aaddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            got_q       <= got_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (state_d == ST_DONE) ? err_d : ERR_OK;
            rd_valid_q  <= cap;
            if (cap) begin
                rd_data_q <= asmi_dataout;
            end
            read_q  <= (state_d == ST_RD_REQ);
            write_q <= (state_d == ST_PROG_REQ);
            erase_q <= (state_d == ST_ER_REQ);
            wren_q  <= (state_d == ST_PROG_REQ) || (state_d == ST_ER_REQ);
            // Stall decision uses busy as seen this cycle, so it takes effect next cycle.
            shift_q <= (state_d == ST_SHIFT) && !asmi_busy;
            rden_q  <= (state_d == ST_RD_REQ) ||
                       (rden_q && !asmi_data_valid && state_d != ST_DONE && state_d != ST_IDLE);
            if (state_d == ST_PROG_REQ || state_d == ST_ER_REQ || state_d == ST_RD_REQ) begin
                aaddr_q <= addr_d;
            end
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign done              = done_q;
    assign err               = err_q;
    assign rd_valid          = rd_valid_q;
    assign rd_data           = rd_data_q;
    assign asmi_read         = read_q;
    assign asmi_rden         = rden_q;
    assign asmi_write        = write_q;
    assign asmi_wren         = wren_q;
    assign asmi_shift_bytes  = shift_q;
    assign asmi_sector_erase = erase_q;
    assign asmi_bulk_erase   = 1'b0;
    assign asmi_addr         = aaddr_q;
    // RAM output register is not reset; qualify it so datain reads 0 outside shifting.
    assign asmi_datain       = shift_q ? buf_rdata : 8'h00;
    assign asmi_en4b_addr    = 1'b1;

endmodule

// File: tb/tb_epcq_flash_sequencer.sv
module tb_epcq_flash_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic        buf_we = 1'b0;
    logic [7:0]  buf_waddr = 8'd0;
    logic [7:0]  buf_wdata = 8'd0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done;
    logic [1:0]  err;
    logic        asmi_read, asmi_rden, asmi_write, asmi_wren, asmi_shift_bytes;
    logic        asmi_sector_erase, asmi_bulk_erase, asmi_en4b_addr;
    logic [31:0] asmi_addr;
    logic [7:0]  asmi_datain;
    logic [7:0]  asmi_dataout = 8'd0;
    logic        asmi_busy = 1'b0;
    logic        asmi_data_valid = 1'b0;
    logic        asmi_illegal_write = 1'b0;
    logic        asmi_illegal_erase = 1'b0;

    epcq_flash_sequencer #(.BUSY_TIMEOUT(100)) dut (
        .clkin(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .asmi_read(asmi_read), .asmi_rden(asmi_rden), .asmi_write(asmi_write),
        .asmi_wren(asmi_wren), .asmi_shift_bytes(asmi_shift_bytes),
        .asmi_sector_erase(asmi_sector_erase), .asmi_bulk_erase(asmi_bulk_erase),
        .asmi_addr(asmi_addr), .asmi_datain(asmi_datain), .asmi_en4b_addr(asmi_en4b_addr),
        .asmi_dataout(asmi_dataout), .asmi_busy(asmi_busy), .asmi_data_valid(asmi_data_valid),
        .asmi_illegal_write(asmi_illegal_write), .asmi_illegal_erase(asmi_illegal_erase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash IP model configuration (written by the stimulus only).
    int m_busy_len = 5;
    bit m_stuck = 1'b0, m_ill_w = 1'b0, m_ill_e = 1'b0, m_no_dv = 1'b0;

    // Model state and monitor records (written by the negedge process only).
    int mcnt = 0;
    bit stk = 1'b0, pend = 1'b0;
    logic [31:0] m_raddr = 32'd0;
    int n_shift = 0, n_wr = 0, n_er = 0, n_rd = 0, n_rdv = 0, n_done = 0, n_bad = 0;
    int wr_cyc = 0, er_cyc = 0;
    logic [7:0]  shq[$];
    logic [31:0] aq[$];
    logic [7:0]  rdq[$];

    always @(negedge clk) begin
        if (asmi_shift_bytes) begin n_shift++; shq.push_back(asmi_datain); end
        if (asmi_write) begin n_wr++; wr_cyc = cyc; aq.push_back(asmi_addr); end
        if (asmi_sector_erase) begin n_er++; er_cyc = cyc; aq.push_back(asmi_addr); end
        if (asmi_read) begin n_rd++; aq.push_back(asmi_addr); end
        if (asmi_wren !== (asmi_write | asmi_sector_erase)) n_bad++;
        if (asmi_bulk_erase !== 1'b0 || asmi_en4b_addr !== 1'b1) n_bad++;
        if (asmi_read && !asmi_rden) n_bad++;
        if (rd_valid) begin
            n_rdv++;
            rdq.push_back(rd_data);
            if (!asmi_data_valid || rd_data !== asmi_dataout) n_bad++;
        end
        if (done) n_done++;
        // IP model: busy for m_busy_len cycles after a strobe, data one cycle before busy falls.
        asmi_data_valid    = 1'b0;
        asmi_illegal_write = 1'b0;
        asmi_illegal_erase = 1'b0;
        if (asmi_read || asmi_write || asmi_sector_erase) begin
            mcnt = m_busy_len;
            stk = m_stuck;
            pend = asmi_read;
            m_raddr = asmi_addr;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 1 && pend && !m_no_dv) begin
                asmi_data_valid = 1'b1;
                asmi_dataout = m_raddr[7:0] ^ 8'h5A;
            end
            if (mcnt == 0) begin
                asmi_illegal_write = m_ill_w;
                asmi_illegal_erase = m_ill_e;
            end
        end
        if (!m_stuck) stk = 1'b0;
        asmi_busy = (mcnt > 0) || stk;
    end

    int acc_cyc = 0;

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [7:0] l);
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
        if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit got, output logic [1:0] e, output int lat);
        got = 1'b0; e = 2'b00; lat = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin got = 1'b1; e = err; lat = cyc - acc_cyc; break; end
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] exp_buf(input int k);
        case (k)
            0: return 8'hA1;
            1: return 8'hB2;
            2: return 8'hC3;
            3: return 8'hD4;
            default: return 8'(k) ^ 8'h3C;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [7:0]  len;
        int          busy;
        bit          ill_w, ill_e, no_dv;
        logic [1:0]  err;
        int          nreq;
        logic [31:0] addr0;
        int          nshift;
        int          nrdv;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl[NV];

    bit got;
    logic [1:0] e;
    int lat;
    int b_req, b_sh, b_rdv, b_bad, b_done, qa, qs, qr;
    logic [31:0] ea;

    initial begin
        //            op     addr          len    busy w e nodv err  nreq addr0        nsh nrdv
        tbl[0]  = '{2'b10, 32'h0001_0000, 8'h00, 50, 0, 0, 0, 2'b00, 1, 32'h0001_0000, 0,  0};
        tbl[1]  = '{2'b01, 32'h0000_0100, 8'h03, 10, 0, 0, 0, 2'b00, 1, 32'h0000_0100, 4,  0};
        tbl[2]  = '{2'b01, 32'h0000_01F0, 8'h1F, 10, 0, 0, 0, 2'b11, 0, 32'h0,         0,  0};
        tbl[3]  = '{2'b01, 32'h0000_01E0, 8'h1F, 10, 0, 0, 0, 2'b00, 1, 32'h0000_01E0, 32, 0};
        tbl[4]  = '{2'b11, 32'h0000_0000, 8'h00, 10, 0, 0, 0, 2'b11, 0, 32'h0,         0,  0};
        tbl[5]  = '{2'b00, 32'hFFFF_FFFF, 8'h02, 5,  0, 0, 0, 2'b00, 3, 32'hFFFF_FFFF, 0,  3};
        tbl[6]  = '{2'b10, 32'h0002_0000, 8'h00, 8,  0, 1, 0, 2'b01, 1, 32'h0002_0000, 0,  0};
        tbl[7]  = '{2'b01, 32'h0000_0300, 8'h00, 8,  1, 0, 0, 2'b01, 1, 32'h0000_0300, 1,  0};
        tbl[8]  = '{2'b00, 32'h0000_0040, 8'h00, 5,  0, 0, 1, 2'b10, 1, 32'h0000_0040, 0,  0};
        tbl[9]  = '{2'b10, 32'h0003_0000, 8'h00, 0,  0, 0, 0, 2'b10, 1, 32'h0003_0000, 0,  0};
        tbl[10] = '{2'b00, 32'h0000_0010, 8'h00, 4,  0, 0, 0, 2'b00, 1, 32'h0000_0010, 0,  1};
        tbl[11] = '{2'b01, 32'h0000_0400, 8'h01, 6,  0, 1, 0, 2'b00, 1, 32'h0000_0400, 2,  0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_done_err_rdv", {29'd0, done, err}, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ctrls", {26'd0, asmi_read, asmi_rden, asmi_write, asmi_wren,
                            asmi_shift_bytes, asmi_sector_erase}, 32'd0);
        check("rst_addr", asmi_addr, 32'd0);
        check("rst_datain_en4b", {23'd0, asmi_en4b_addr, asmi_datain}, 32'h100);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Fill the page buffer.
        for (int k = 0; k < 256; k++) begin
            buf_we = 1'b1; buf_waddr = 8'(k); buf_wdata = exp_buf(k);
            @(negedge clk);
        end
        buf_we = 1'b0;

        for (int v = 0; v < NV; v++) begin
            m_busy_len = tbl[v].busy; m_ill_w = tbl[v].ill_w;
            m_ill_e = tbl[v].ill_e; m_no_dv = tbl[v].no_dv;
            b_req = n_wr + n_er + n_rd; b_sh = n_shift; b_rdv = n_rdv; b_bad = n_bad;
            qa = aq.size(); qs = shq.size(); qr = rdq.size();
            issue(tbl[v].op, tbl[v].addr, tbl[v].len);
            wait_done(got, e, lat);
            check($sformatf("v%0d done_seen", v), 32'(got), 32'd1);
            check($sformatf("v%0d err", v), 32'(e), 32'(tbl[v].err));
            if (tbl[v].err == 2'b11) check($sformatf("v%0d arg_lat", v), lat, 32'd2);
            @(negedge clk);
            check($sformatf("v%0d done_pulse", v), 32'(done), 32'd0);
            check($sformatf("v%0d nreq", v), n_wr + n_er + n_rd - b_req, tbl[v].nreq);
            check($sformatf("v%0d nshift", v), n_shift - b_sh, tbl[v].nshift);
            check($sformatf("v%0d nrdv", v), n_rdv - b_rdv, tbl[v].nrdv);
            check($sformatf("v%0d protocol", v), n_bad - b_bad, 32'd0);
            for (int k = 0; k < tbl[v].nreq && qa + k < aq.size(); k++)
                check($sformatf("v%0d addr%0d", v, k), aq[qa + k], tbl[v].addr0 + 32'(k));
            for (int k = 0; k < tbl[v].nshift && qs + k < shq.size(); k++)
                check($sformatf("v%0d byte%0d", v, k), 32'(shq[qs + k]), 32'(exp_buf(k)));
            for (int k = 0; k < tbl[v].nrdv && qr + k < rdq.size(); k++) begin
                ea = tbl[v].addr0 + 32'(k);
                check($sformatf("v%0d rdata%0d", v, k), 32'(rdq[qr + k]), 32'(ea[7:0] ^ 8'h5A));
            end
        end

        // Buffer writes outside IDLE are ignored; then exact program timing.
        m_busy_len = 30; m_ill_w = 0; m_ill_e = 0; m_no_dv = 0;
        issue(2'b10, 32'h0004_0000, 8'h00);
        buf_we = 1'b1; buf_waddr = 8'h00; buf_wdata = 8'hEE;
        @(negedge clk);
        buf_we = 1'b0;
        wait_done(got, e, lat);
        check("bufwr_erase_done", 32'(got), 32'd1);
        m_busy_len = 6;
        qs = shq.size(); b_sh = n_shift;
        issue(2'b01, 32'h0000_0100, 8'h03);
        wait_done(got, e, lat);
        check("prog_err", {31'd0, got} << 2 | 32'(e), 32'd4);
        check("prog_write_cycle", wr_cyc - acc_cyc, 32'd6);
        check("prog_nshift", n_shift - b_sh, 32'd4);
        check("prog_byte0_kept", (qs < shq.size()) ? 32'(shq[qs]) : 32'hFFFF, 32'hA1);
        check("prog_byte3", (qs + 3 < shq.size()) ? 32'(shq[qs + 3]) : 32'hFFFF, 32'hD4);

        // Busy stuck high: timeout on the 100th WAIT_LO cycle.
        m_busy_len = 1; m_stuck = 1'b1;
        issue(2'b10, 32'h0005_0000, 8'h00);
        wait_done(got, e, lat);
        check("tmo_err", {31'd0, got} << 2 | 32'(e), 32'd6);
        check("tmo_cycle", acc_cyc + lat - er_cyc, 32'd102);
        m_stuck = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a 256-byte program.
        issue(2'b01, 32'h0000_0200, 8'hFF);
        repeat (10) @(negedge clk);
        check("mid_shift_active", 32'(asmi_shift_bytes), 32'd1);
        b_done = n_done;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrls", {25'd0, asmi_read, asmi_rden, asmi_write, asmi_wren,
                                asmi_shift_bytes, asmi_sector_erase, done}, 32'd0);
        check("rst_mid_datain", 32'(asmi_datain), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", n_done - b_done, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
